// File: rtl/alu4_word_sequencer_if.sv
// Host-side start/busy/done handshake and word-level operand/result bus
// for the nibble-serial ALU sequencer.
interface alu4_word_sequencer_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         rot_in;
    logic         msb_first;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         rot_out;
    logic         zero_out;
    logic         ovf_out;

    modport master (
        output start, op, a, b, carry_in, rot_in, msb_first,
        input  busy, done, result, carry_out, rot_out, zero_out, ovf_out
    );

    modport slave (
        input  start, op, a, b, carry_in, rot_in, msb_first,
        output busy, done, result, carry_out, rot_out, zero_out, ovf_out
    );
endinterface

// File: rtl/alu4_word_sequencer.sv
// Word-wide operation sequencer: issues one nibble per cycle to a 4-bit
// combinational ALU, chaining math/rotate carries and reassembling the word.
module alu4_word_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu4_word_sequencer_if.slave  host,
    output logic [3:0]            alu_op,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic                  alu_mc,
    output logic                  alu_rc,
    input  logic [3:0]            alu_out,
    input  logic                  alu_mco,
    input  logic                  alu_rco,
    input  logic                  alu_ovf,
    input  logic                  alu_zero
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam logic [2:0]  LAST = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_next;
    logic [3:0]   op_q;
    logic [W-1:0] a_q, b_q, result_q;
    logic         mc_q, rc_q, msb_q;
    logic [2:0]   k;
    logic         zacc, zacc_next;
    logic         ovf_q, carry_out_q, rot_out_q, zero_q;
    logic         accept;
    logic [2:0]   idx;
    logic [4:0]   bit_lo;

    assign accept    = host.start && (state != RUN);
    assign idx       = msb_q ? (LAST - k) : k;
    assign bit_lo    = {idx, 2'b00};
    assign zacc_next = (k == 3'd0) ? alu_zero : (zacc & alu_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (host.start) state_next = RUN;
            RUN:     if (k == LAST)  state_next = DONE;
            DONE:    state_next = host.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        host.busy = (state == RUN);
        host.done = (state == DONE);
        alu_op    = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_mc    = 1'b0;
        alu_rc    = 1'b0;
        if (state == RUN) begin
            alu_op = op_q;
            alu_a  = a_q[bit_lo +: 4];
            alu_b  = b_q[bit_lo +: 4];
            alu_mc = mc_q;
            alu_rc = rc_q;
        end
    end

    // mc_q/rc_q hold carry_in/rot_in at step 0 and the previous nibble's carries after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            mc_q        <= 1'b0;
            rc_q        <= 1'b0;
            msb_q       <= 1'b0;
            k           <= '0;
            result_q    <= '0;
            zacc        <= 1'b0;
            ovf_q       <= 1'b0;
            carry_out_q <= 1'b0;
            rot_out_q   <= 1'b0;
            zero_q      <= 1'b0;
        end else if (accept) begin
            op_q  <= host.op;
            a_q   <= host.a;
            b_q   <= host.b;
            mc_q  <= host.carry_in;
            rc_q  <= host.rot_in;
            msb_q <= host.msb_first;
            k     <= '0;
        end else if (state == RUN) begin
            result_q[bit_lo +: 4] <= alu_out;
            mc_q <= alu_mco;
            rc_q <= alu_rco;
            zacc <= zacc_next;
            if (idx == LAST) ovf_q <= alu_ovf;
            k <= k + 3'd1;
            if (k == LAST) begin
                carry_out_q <= alu_mco;
                rot_out_q   <= alu_rco;
                zero_q      <= zacc_next;
            end
        end
    end

    assign host.result    = result_q;
    assign host.carry_out = carry_out_q;
    assign host.rot_out   = rot_out_q;
    assign host.zero_out  = zero_q;
    assign host.ovf_out   = ovf_q;
endmodule
